bridge_router: RTL
==================

BRIDGE_ROUTER -- requirements
Module: bridge_router

Interface
REQ-001 Parameter NUM_LEAVES, default 6; number of downstream leaf ports, 1..16.
REQ-002 Parameter ADDR_RANGES, default all-zero; array[NUM_LEAVES] of pocket::bridge_addr_range_t (from_addr, to_addr, inclusive).
REQ-003 Parameter RD_LATENCY, default 1; leaf cycles from leaf_rd to valid leaf_rd_data, 0..7.
REQ-004 Parameter REL_ADDR, default 0; 1 = forward address minus matched from_addr, 0 = forward full address.
REQ-005 Parameter ENDIAN_LITTLE, default 0; driven onto bridge_endian_little.
REQ-006 Parameter UNMAPPED_DATA, default 32'h0; read data returned for unmapped addresses.
REQ-007 The clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-008 clk_74a  in  1  bridge clock; all logic on rising edge.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 bridge_addr  in  32  host address.
REQ-011 bridge_wr / bridge_rd  in  1 each  single-cycle write / read strobes.
REQ-012 bridge_wr_data  in  32  write data.
REQ-013 bridge_rd_data  out  32  read return data.
REQ-014 bridge_endian_little  out  1  constant ENDIAN_LITTLE.
REQ-015 leaf_addr  out  32  shared forwarded address.
REQ-016 leaf_wr_data  out  32  shared forwarded write data.
REQ-017 leaf_wr / leaf_rd  out  NUM_LEAVES each  one-hot per-leaf strobes.
REQ-018 leaf_rd_data  in  NUM_LEAVES x 32  per-leaf read data.
REQ-019 unmapped_count  out  16  saturating count of unmapped accesses.
REQ-020 last_unmapped_addr  out  32  address of most recent unmapped access.

Function
REQ-021 Decode: leaf i matches when from_addr <= addr <= to_addr (unsigned); on overlap the lowest index wins.
REQ-022 Request stage registered: strobe in cycle T drives leaf_addr, leaf_wr_data, leaf_wr[i]/leaf_rd[i] in cycle T+1 for exactly one cycle.
REQ-023 At most one bit of leaf_wr|leaf_rd is set in any cycle.
REQ-024 bridge_wr and bridge_rd together: write performed, read discarded, no read return.
REQ-025 Read tag pipeline (valid, mapped, index) RD_LATENCY+1 deep; back-to-back reads every cycle supported without stall.
REQ-026 bridge_rd_data updated registered at T+RD_LATENCY+2 with leaf_rd_data[index], or UNMAPPED_DATA when unmapped.
REQ-027 bridge_rd_data holds its value until the next read return.
REQ-028 Unmapped write: no leaf strobe; data dropped.
REQ-029 Unmapped read or write: unmapped_count += 1 (saturates at 16'hFFFF), last_unmapped_addr <= bridge_addr, both at T+1.
REQ-030 REL_ADDR=1: leaf_addr = bridge_addr - from_addr of matched leaf, 32-bit wrap; unmapped forwards full address.
REQ-031 leaf_addr and leaf_wr_data update only on a strobe; otherwise hold.

Reset
REQ-032 reset_n low: leaf_wr, leaf_rd, tag pipeline, bridge_rd_data, unmapped_count, last_unmapped_addr, leaf_addr, leaf_wr_data all cleared to 0 immediately.
REQ-033 Reads in flight at reset are discarded; no return after reset release.
REQ-034 First strobe accepted in the first clock edge after reset_n rises.

Structure
REQ-035 bridge_addr_range_t lives in package pocket; router-internal tag type lives in bridge_pkg.
REQ-036 One sub-module: bridge_addr_decode (combinational priority match -> hit, index, base).

Verification
REQ-037 Ranges {0x0-0xFF, 0x100-0x1FF}, RD_LATENCY=1: read 0x104, leaf1 returns 0xCAFEF00D -> leaf_rd=2'b10 at T+1, bridge_rd_data=0xCAFEF00D at T+3.
REQ-038 Reads 0x10, 0x110, 0x20 on consecutive cycles -> returns in order at T+3, T+4, T+5 with correct leaf data.
REQ-039 Read 0x9000 (unmapped) -> no leaf strobe, bridge_rd_data=UNMAPPED_DATA, unmapped_count=1, last_unmapped_addr=0x9000.
REQ-040 REL_ADDR=1, write 0x1A4 data 0x55 -> leaf_wr=2'b10, leaf_addr=0xA4, leaf_wr_data=0x55 at T+1.
REQ-041 Overlap {0x0-0x1FF, 0x100-0x1FF}, access 0x180 -> leaf0 selected only.
REQ-042 Read issued, reset_n pulsed low before return -> bridge_rd_data stays 0, count 0, no strobes.

Source files
------------

// File: rtl/bridge_pkg.sv
// Router-internal types: the read tag that travels alongside the leaf read latency.
package bridge_pkg;

  localparam int IDX_W = 4;

  typedef struct packed {
    logic             vld;
    logic             mapped;
    logic [IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/pocket_pkg.sv
// Shared platform types for the host bridge: one inclusive address window per leaf.
package pocket;

  typedef struct packed {
    logic [31:0] from_addr;
    logic [31:0] to_addr;
  } bridge_addr_range_t;

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decode: first (lowest-index) matching window wins.
module bridge_addr_decode
  import pocket::*;
  import bridge_pkg::*;
#(
  parameter int                                  NUM_LEAVES  = 6,
  parameter bridge_addr_range_t [NUM_LEAVES-1:0] ADDR_RANGES = '0
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [31:0]      base_o
);

  // Walk from the top so a lower-index match overwrites a higher one.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    base_o = '0;
    for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
      if (addr_i >= ADDR_RANGES[i].from_addr && addr_i <= ADDR_RANGES[i].to_addr) begin
        hit_o  = 1'b1;
        idx_o  = IDX_W'(i);
        base_o = ADDR_RANGES[i].from_addr;
      end
    end
  end

endmodule

// File: rtl/bridge_router.sv
// Host bridge fan-out: registered request stage to one-hot leaf strobes, tagged read return.
module bridge_router
  import pocket::*;
  import bridge_pkg::*;
#(
  parameter int                                  NUM_LEAVES    = 6,
  parameter bridge_addr_range_t [NUM_LEAVES-1:0] ADDR_RANGES   = '0,
  parameter int                                  RD_LATENCY    = 1,
  parameter int                                  REL_ADDR      = 0,
  parameter bit                                  ENDIAN_LITTLE = 1'b0,
  parameter logic [31:0]                         UNMAPPED_DATA = 32'h0
) (
  input  logic                       clk_74a,
  input  logic                       reset_n,
  input  logic [31:0]                bridge_addr,
  input  logic                       bridge_wr,
  input  logic                       bridge_rd,
  input  logic [31:0]                bridge_wr_data,
  output logic [31:0]                bridge_rd_data,
  output logic                       bridge_endian_little,
  output logic [31:0]                leaf_addr,
  output logic [31:0]                leaf_wr_data,
  output logic [NUM_LEAVES-1:0]      leaf_wr,
  output logic [NUM_LEAVES-1:0]      leaf_rd,
  input  logic [NUM_LEAVES-1:0][31:0] leaf_rd_data,
  output logic [15:0]                unmapped_count,
  output logic [31:0]                last_unmapped_addr
);

  localparam int LAT = RD_LATENCY;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic [31:0]      dec_base;

  bridge_addr_decode #(
    .NUM_LEAVES (NUM_LEAVES),
    .ADDR_RANGES(ADDR_RANGES)
  ) u_dec (
    .addr_i(bridge_addr),
    .hit_o (dec_hit),
    .idx_o (dec_idx),
    .base_o(dec_base)
  );

  logic strobe, rd_only;
  assign strobe  = bridge_wr | bridge_rd;
  // A simultaneous write wins; the read half is silently dropped.
  assign rd_only = bridge_rd & ~bridge_wr;

  logic [NUM_LEAVES-1:0] leaf_wr_d, leaf_rd_d, leaf_wr_q, leaf_rd_q;
  logic [31:0]           leaf_addr_d, leaf_addr_q, leaf_wr_data_q;
  logic [15:0]           unm_cnt_d, unm_cnt_q;
  logic [31:0]           unm_addr_q;
  rd_tag_t               tag_d;
  rd_tag_t [LAT:0]       tag_q;
  logic [31:0]           rd_sel, rd_data_d, rd_data_q;

  always_comb begin
    leaf_wr_d = '0;
    leaf_rd_d = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (dec_hit && dec_idx == IDX_W'(i)) begin
        leaf_wr_d[i] = bridge_wr;
        leaf_rd_d[i] = rd_only;
      end
    end
    leaf_addr_d = (REL_ADDR != 0 && dec_hit) ? bridge_addr - dec_base : bridge_addr;
    unm_cnt_d   = (unm_cnt_q == 16'hFFFF) ? unm_cnt_q : unm_cnt_q + 16'd1;
    tag_d       = '{vld: rd_only, mapped: dec_hit, idx: dec_idx};
  end

  // Tail of the tag pipe lines up with the cycle the leaf data is valid.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (tag_q[LAT].idx == IDX_W'(i)) rd_sel = leaf_rd_data[i];
    end
    rd_data_d = tag_q[LAT].mapped ? rd_sel : UNMAPPED_DATA;
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      leaf_wr_q      <= '0;
      leaf_rd_q      <= '0;
      leaf_addr_q    <= '0;
      leaf_wr_data_q <= '0;
      unm_cnt_q      <= '0;
      unm_addr_q     <= '0;
      tag_q          <= '0;
      rd_data_q      <= '0;
    end else begin
      leaf_wr_q <= leaf_wr_d;
      leaf_rd_q <= leaf_rd_d;
      if (strobe) begin
        leaf_addr_q    <= leaf_addr_d;
        leaf_wr_data_q <= bridge_wr_data;
      end
      if (strobe && !dec_hit) begin
        unm_cnt_q  <= unm_cnt_d;
        unm_addr_q <= bridge_addr;
      end
      tag_q[0] <= tag_d;
      for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
      if (tag_q[LAT].vld) rd_data_q <= rd_data_d;
    end
  end

  assign leaf_wr              = leaf_wr_q;
  assign leaf_rd              = leaf_rd_q;
  assign leaf_addr            = leaf_addr_q;
  assign leaf_wr_data         = leaf_wr_data_q;
  assign unmapped_count       = unm_cnt_q;
  assign last_unmapped_addr   = unm_addr_q;
  assign bridge_rd_data       = rd_data_q;
  assign bridge_endian_little = ENDIAN_LITTLE;

endmodule
